bus_seq_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core. It turns the single-cycle datapath into a handshaked bus master.
- Gates PC update and register-file write until the instruction-memory acknowledge (ACKI_n) and the data-memory acknowledge (ACKD_n) arrive.
- Drives the external data-bus control signals MREQ, WRITE, SIZE and the DDT output enable.
- Sits in the core top level, between the decoder/ALU outputs and the pc and rf32x32 instances.

---
 rtl/bus_seq_ctrl_pkg.sv | 45 ++++
 rtl/bus_seq_ctrl_if.sv | 29 ++
 rtl/bus_seq_ctrl_wait_timer.sv | 38 +++
 rtl/bus_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_bus_seq_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// bus_seq_ctrl_pkg
// Shared definitions for the RV32I bus sequencer: the state encoding, the
// external SIZE codes, the funct3 access-width field, and small helpers that
// map funct3 onto the bus and check address alignment.
// ---------------------------------------------------------------------------
package bus_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'b00,
        EXEC  = 2'b01,
        DMEM  = 2'b10,
        HALT  = 2'b11
    } seq_state_t;

    // External SIZE pin encoding
    localparam logic [1:0] SZ_BYTE = 2'b11;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b00;

    // funct3 field: [1:0] is the access width, [2] is the load sign control
    localparam int         FUNCT3_W = 3;
    localparam logic [1:0] F3_BYTE  = 2'b00;
    localparam logic [1:0] F3_HALF  = 2'b01;
    localparam logic [1:0] F3_WORD  = 2'b10;
    localparam logic [1:0] F3_BAD   = 2'b11;

    function automatic logic [1:0] size_code(input logic [1:0] width);
        case (width)
            F3_BYTE: size_code = SZ_BYTE;
            F3_HALF: size_code = SZ_HALF;
            default: size_code = SZ_WORD;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] width,
                                        input logic [1:0] addr_lo);
        case (width)
            F3_HALF: misaligned = addr_lo[0];
            F3_WORD: misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/bus_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_seq_ctrl_if
// External memory handshake of the core.
//   ACKI_n  instruction-memory acknowledge, active low
//   ACKD_n  data-memory acknowledge, active low
//   MREQ    data-memory request
//   WRITE   data-memory write
//   SIZE    access width (11 byte, 01 half, 00 word)
//   ddt_oe  core drives the DDT data bus
// master: the sequencer side; slave: the memory / environment side.
// ---------------------------------------------------------------------------
interface bus_seq_ctrl_if;
    logic       ACKI_n;
    logic       ACKD_n;
    logic       MREQ;
    logic       WRITE;
    logic [1:0] SIZE;
    logic       ddt_oe;

    modport master (
        input  ACKI_n, ACKD_n,
        output MREQ, WRITE, SIZE, ddt_oe
    );

    modport slave (
        output ACKI_n, ACKD_n,
        input  MREQ, WRITE, SIZE, ddt_oe
    );
endinterface

// File: rtl/bus_seq_ctrl_wait_timer.sv
// ---------------------------------------------------------------------------
// bus_wait_timer
// Saturating wait-cycle counter for acknowledge timeouts.
//   clk, rst  clock and synchronous active-low reset
//   clear     zero the count (takes priority over count_en)
//   count_en  advance the count by one
//   expired   count has reached TIMEOUT_CYCLES
// The count stops at TIMEOUT_CYCLES so it can never wrap back to zero and
// hide a timeout.
// ---------------------------------------------------------------------------
module bus_wait_timer #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count_en,
    output logic expired
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count_en && (count != LIMIT)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LIMIT);

endmodule

// File: rtl/bus_seq_ctrl.sv
// ---------------------------------------------------------------------------
// bus_seq_ctrl
// Multi-cycle sequencer that turns the single-cycle RV32I datapath into a
// handshaked bus master. It gates PC update and register-file write on the
// instruction and data acknowledges and drives the data-bus controls.
//
// Ports
//   clk, rst        core clock, synchronous active-low reset
//   bus             memory handshake (master modport)
//   dec_mem_read    decoder load flag
//   dec_mem_write   decoder store flag
//   dec_reg_write   decoder register-write request
//   dec_funct3      access width / sign field
//   alu_addr        effective data address, only [1:0] is used
//   pc_en           one-cycle PC load strobe
//   rf_we           one-cycle register-file write strobe
//   ld_capture      one-cycle strobe to latch DDT load data
//   bus_err         sticky error flag, cleared only by reset
//   state_o         current state, debug
//
// state | meaning
// FETCH | waiting for the instruction acknowledge
// EXEC  | one cycle: decoder sampled, ALU ops retire, memory ops launch
// DMEM  | data access on the bus, waiting for the data acknowledge
// HALT  | bus error; left only through reset
// ---------------------------------------------------------------------------
module bus_seq_ctrl
    import bus_seq_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                rst,
    bus_seq_ctrl_if.master      bus,
    input  logic                dec_mem_read,
    input  logic                dec_mem_write,
    input  logic                dec_reg_write,
    input  logic [FUNCT3_W-1:0] dec_funct3,
    input  logic [31:0]         alu_addr,
    output logic                pc_en,
    output logic                rf_we,
    output logic                ld_capture,
    output logic                bus_err,
    output logic [1:0]          state_o
);

    seq_state_t state;
    seq_state_t state_nxt;

    logic       mreq_q;
    logic       write_q;
    logic [1:0] size_q;
    logic       oe_q;
    logic       err_q;
    logic       load_q;
    logic       reg_write_q;

    logic       pc_en_c;
    logic       rf_we_c;
    logic       ld_c;
    logic       mem_op;
    logic       expired;
    logic       wait_en;
    logic       unused_bits;

    // Upper address bits and the load sign bit belong to the datapath.
    assign unused_bits = ^{alu_addr[31:2], dec_funct3[2]};

    assign mem_op = dec_mem_read | dec_mem_write;

    always_comb begin
        state_nxt = state;
        pc_en_c   = 1'b0;
        rf_we_c   = 1'b0;
        ld_c      = 1'b0;
        case (state)
            FETCH: begin
                // An acknowledge in the timeout cycle still wins.
                if (!bus.ACKI_n) begin
                    state_nxt = EXEC;
                end else if (expired) begin
                    state_nxt = HALT;
                end
            end
            EXEC: begin
                if (dec_mem_read && dec_mem_write) begin
                    state_nxt = HALT;
                end else if (mem_op) begin
                    if ((dec_funct3[1:0] == F3_BAD) ||
                        misaligned(dec_funct3[1:0], alu_addr[1:0])) begin
                        state_nxt = HALT;
                    end else begin
                        state_nxt = DMEM;
                    end
                end else begin
                    state_nxt = FETCH;
                    pc_en_c   = 1'b1;
                    rf_we_c   = dec_reg_write;
                end
            end
            DMEM: begin
                if (!bus.ACKD_n) begin
                    state_nxt = FETCH;
                    pc_en_c   = 1'b1;
                    ld_c      = load_q;
                    rf_we_c   = load_q & reg_write_q;
                end else if (expired) begin
                    state_nxt = HALT;
                end
            end
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= FETCH;
            mreq_q      <= 1'b0;
            write_q     <= 1'b0;
            size_q      <= SZ_WORD;
            oe_q        <= 1'b0;
            err_q       <= 1'b0;
            load_q      <= 1'b0;
            reg_write_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state_nxt == HALT) begin
                err_q <= 1'b1;
            end
            if ((state == EXEC) && (state_nxt == DMEM)) begin
                mreq_q      <= 1'b1;
                write_q     <= dec_mem_write;
                oe_q        <= dec_mem_write;
                size_q      <= size_code(dec_funct3[1:0]);
                load_q      <= dec_mem_read;
                reg_write_q <= dec_reg_write;
            end else if (state_nxt != DMEM) begin
                mreq_q  <= 1'b0;
                write_q <= 1'b0;
                oe_q    <= 1'b0;
                size_q  <= SZ_WORD;
            end
        end
    end

    // Each state waits on at most one acknowledge; any state change restarts
    // the wait count.
    assign wait_en = ((state == FETCH) && bus.ACKI_n) ||
                     ((state == DMEM)  && bus.ACKD_n);

    bus_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_nxt != state),
        .count_en (wait_en),
        .expired  (expired)
    );

    // Strobes are suppressed while reset is asserted so that an acknowledge
    // arriving in the reset cycle cannot retire a half-finished access.
    assign pc_en      = rst & pc_en_c;
    assign rf_we      = rst & rf_we_c;
    assign ld_capture = rst & ld_c;

    assign bus.MREQ   = mreq_q;
    assign bus.WRITE  = write_q;
    assign bus.SIZE   = size_q;
    assign bus.ddt_oe = oe_q;
    assign bus_err    = err_q;
    assign state_o    = state;

endmodule

// File: tb/tb_bus_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bus_seq_ctrl
// Scoreboard bench for bus_seq_ctrl. Each cycle's expected output vector is
// queued as the stimulus for that cycle is applied and popped when the
// outputs are sampled on the falling edge.
// Vector layout: {state[1:0], pc_en, rf_we, ld_capture,
//                 MREQ, WRITE, SIZE[1:0], ddt_oe, bus_err}
// ---------------------------------------------------------------------------
module tb_bus_seq_ctrl;
    import bus_seq_ctrl_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        dec_mem_read;
    logic        dec_mem_write;
    logic        dec_reg_write;
    logic [2:0]  dec_funct3;
    logic [31:0] alu_addr;
    logic        pc_en;
    logic        rf_we;
    logic        ld_capture;
    logic        bus_err;
    logic [1:0]  state_o;

    logic [10:0] exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;

    bus_seq_ctrl_if bus ();

    bus_seq_ctrl #(
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .dec_mem_read  (dec_mem_read),
        .dec_mem_write (dec_mem_write),
        .dec_reg_write (dec_reg_write),
        .dec_funct3    (dec_funct3),
        .alu_addr      (alu_addr),
        .pc_en         (pc_en),
        .rf_we         (rf_we),
        .ld_capture    (ld_capture),
        .bus_err       (bus_err),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    // stb = {pc_en, rf_we, ld_capture}; bs = {MREQ, WRITE, SIZE, ddt_oe}
    function automatic logic [10:0] ev(input logic [1:0] st,
                                       input logic [2:0] stb,
                                       input logic [4:0] bs,
                                       input logic       er);
        ev = {st, stb, bs, er};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs,
                       input logic [10:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_err++;
            $display("FAIL %s: got %b want %b", tag, obs, want);
        end
    endtask

    task automatic step(input string tag, input logic acki, input logic ackd,
                        input logic [10:0] want);
        logic [10:0] obs;
        bus.ACKI_n = acki;
        bus.ACKD_n = ackd;
        exp_q.push_back(want);
        @(negedge clk);
        obs = {state_o, pc_en, rf_we, ld_capture,
               bus.MREQ, bus.WRITE, bus.SIZE, bus.ddt_oe, bus_err};
        chk(tag, obs, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    task automatic set_dec(input logic rd, input logic wr, input logic rw,
                           input logic [2:0] f3, input logic [31:0] addr);
        dec_mem_read  = rd;
        dec_mem_write = wr;
        dec_reg_write = rw;
        dec_funct3    = f3;
        alu_addr      = addr;
    endtask

    // Reset cycle from HALT: outputs still show HALT, then FETCH is clean.
    task automatic reset_from_halt(input string tag);
        rst = 1'b0;
        step({tag, "_rst"}, 1'b0, 1'b0, ev(HALT, 3'b000, 5'b00000, 1'b1));
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        bus.ACKI_n = 1'b1;
        bus.ACKD_n = 1'b1;
        set_dec(1'b0, 1'b0, 1'b0, 3'b000, 32'h0);
        @(posedge clk);
        #1;
        step("reset", 1'b1, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        rst = 1'b1;

        // ALU op with register write
        set_dec(1'b0, 1'b0, 1'b1, 3'b000, 32'h0);
        step("alu_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("alu_exec",  1'b1, 1'b1, ev(EXEC,  3'b110, 5'b00000, 1'b0));
        step("alu_back",  1'b1, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));

        // ALU op, funct3=011 is legal without a memory op, no reg write
        set_dec(1'b0, 1'b0, 1'b0, 3'b011, 32'h3);
        step("alu2_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("alu2_exec",  1'b1, 1'b1, ev(EXEC,  3'b100, 5'b00000, 1'b0));

        // Word load, three ACKD wait cycles; ACKI low during DMEM is ignored
        set_dec(1'b1, 1'b0, 1'b1, 3'b010, 32'h100);
        step("lw_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("lw_exec",  1'b1, 1'b1, ev(EXEC,  3'b000, 5'b00000, 1'b0));
        for (int i = 0; i < 3; i++)
            step("lw_wait", 1'b0, 1'b1, ev(DMEM, 3'b000, 5'b10000, 1'b0));
        step("lw_ack",  1'b1, 1'b0, ev(DMEM,  3'b111, 5'b10000, 1'b0));
        step("lw_back", 1'b1, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));

        // Byte store at an odd address; decoder changes after EXEC must not leak
        set_dec(1'b0, 1'b1, 1'b1, 3'b000, 32'h103);
        step("sb_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("sb_exec",  1'b1, 1'b1, ev(EXEC,  3'b000, 5'b00000, 1'b0));
        set_dec(1'b1, 1'b0, 1'b1, 3'b010, 32'h0);
        for (int i = 0; i < 2; i++)
            step("sb_wait", 1'b1, 1'b1, ev(DMEM, 3'b000, 5'b11111, 1'b0));
        step("sb_ack",  1'b1, 1'b0, ev(DMEM,  3'b100, 5'b11111, 1'b0));
        step("sb_back", 1'b1, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));

        // Misaligned half load goes straight to HALT, acks are ignored there
        set_dec(1'b1, 1'b0, 1'b1, 3'b001, 32'h101);
        step("lh_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("lh_exec",  1'b1, 1'b1, ev(EXEC,  3'b000, 5'b00000, 1'b0));
        step("lh_halt",  1'b0, 1'b0, ev(HALT,  3'b000, 5'b00000, 1'b1));
        step("lh_halt2", 1'b0, 1'b0, ev(HALT,  3'b000, 5'b00000, 1'b1));
        reset_from_halt("lh");

        // Fetch timeout: TO counted wait cycles, then the expiry cycle
        for (int i = 0; i <= TO; i++)
            step("to_fetch", 1'b1, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("to_halt",  1'b0, 1'b1, ev(HALT, 3'b000, 5'b00000, 1'b1));
        step("to_ign",   1'b0, 1'b0, ev(HALT, 3'b000, 5'b00000, 1'b1));
        step("to_ign2",  1'b1, 1'b1, ev(HALT, 3'b000, 5'b00000, 1'b1));
        reset_from_halt("to");

        // Reset in the middle of a DMEM wait, with ACKD arriving in that cycle
        set_dec(1'b1, 1'b0, 1'b1, 3'b010, 32'h8);
        step("rd_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("rd_exec",  1'b1, 1'b1, ev(EXEC,  3'b000, 5'b00000, 1'b0));
        step("rd_wait",  1'b1, 1'b1, ev(DMEM,  3'b000, 5'b10000, 1'b0));
        rst = 1'b0;
        step("rd_rst",   1'b1, 1'b0, ev(DMEM,  3'b000, 5'b10000, 1'b0));
        rst = 1'b1;
        step("rd_after", 1'b1, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));

        // Data timeout on a word store
        set_dec(1'b0, 1'b1, 1'b0, 3'b010, 32'h4);
        step("dto_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("dto_exec",  1'b1, 1'b1, ev(EXEC,  3'b000, 5'b00000, 1'b0));
        for (int i = 0; i <= TO; i++)
            step("dto_wait", 1'b1, 1'b1, ev(DMEM, 3'b000, 5'b11001, 1'b0));
        step("dto_halt", 1'b1, 1'b0, ev(HALT, 3'b000, 5'b00000, 1'b1));
        reset_from_halt("dto");

        // Load and store both flagged
        set_dec(1'b1, 1'b1, 1'b1, 3'b010, 32'h0);
        step("rw_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("rw_exec",  1'b1, 1'b1, ev(EXEC,  3'b000, 5'b00000, 1'b0));
        step("rw_halt",  1'b1, 1'b1, ev(HALT,  3'b000, 5'b00000, 1'b1));
        reset_from_halt("rw");

        // Reserved width on a store
        set_dec(1'b0, 1'b1, 1'b0, 3'b011, 32'h0);
        step("f3_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("f3_exec",  1'b1, 1'b1, ev(EXEC,  3'b000, 5'b00000, 1'b0));
        step("f3_halt",  1'b1, 1'b1, ev(HALT,  3'b000, 5'b00000, 1'b1));
        reset_from_halt("f3");

        // Misaligned word load
        set_dec(1'b1, 1'b0, 1'b1, 3'b010, 32'h102);
        step("mw_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("mw_exec",  1'b1, 1'b1, ev(EXEC,  3'b000, 5'b00000, 1'b0));
        step("mw_halt",  1'b1, 1'b1, ev(HALT,  3'b000, 5'b00000, 1'b1));
        reset_from_halt("mw");

        // Aligned half store with ACKD already low on DMEM entry
        set_dec(1'b0, 1'b1, 1'b0, 3'b101, 32'h102);
        step("sh_fetch", 1'b0, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));
        step("sh_exec",  1'b1, 1'b0, ev(EXEC,  3'b000, 5'b00000, 1'b0));
        step("sh_ack",   1'b1, 1'b0, ev(DMEM,  3'b100, 5'b11011, 1'b0));
        step("sh_back",  1'b1, 1'b1, ev(FETCH, 3'b000, 5'b00000, 1'b0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
